// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: hazard-detect inputs from the pipeline, register enables/clears back to it.
// master = pipeline datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       ex_mem_read;
    logic       ex_mc_start;
    logic       ex_branch_taken;
    logic       ext_stall;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_clr;
    logic       idex_en;
    logic       idex_clr;
    logic       exmem_en;
    logic       exmem_clr;
    logic       memwb_en;
    logic       mc_busy;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, ex_mc_start, ex_branch_taken, ext_stall,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, mc_busy
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, ex_mc_start, ex_branch_taken, ext_stall,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, mc_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipe: load-use, EX-resolved branches, multi-cycle EX freeze.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]   stall_cycles
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic load_use;
    logic mc_freeze;

    logic pc_en_c, ifid_en_c, ifid_clr_c, idex_en_c, idex_clr_c;
    logic exmem_en_c, exmem_clr_c, memwb_en_c, mc_busy_c;

    assign load_use  = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                       ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
    assign mc_freeze = (state == MC_BUSY) || hz.ex_mc_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The start cycle is the first frozen cycle, so MC_BUSY lasts MC_LATENCY-1 cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!hz.ext_stall) begin
            unique case (state)
                RUN: begin
                    if (hz.ex_mc_start) begin
                        state_nx = MC_BUSY;
                        cnt_nx   = CNT_W'(MC_LATENCY - 2);
                    end
                end
                MC_BUSY: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en_c     = 1'b1;
        ifid_en_c   = 1'b1;
        ifid_clr_c  = 1'b0;
        idex_en_c   = 1'b1;
        idex_clr_c  = 1'b0;
        exmem_en_c  = 1'b1;
        exmem_clr_c = 1'b0;
        memwb_en_c  = 1'b1;
        mc_busy_c   = 1'b0;
        if (rst) begin
            pc_en_c     = 1'b0;
            ifid_en_c   = 1'b0;
            ifid_clr_c  = 1'b1;
            idex_en_c   = 1'b0;
            idex_clr_c  = 1'b1;
            exmem_en_c  = 1'b0;
            exmem_clr_c = 1'b1;
            memwb_en_c  = 1'b0;
        end else if (hz.ext_stall) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
            mc_busy_c  = (state == MC_BUSY);
        end else if (mc_freeze) begin
            // Branch and load-use requests are ignored: the multi-cycle op owns EX.
            pc_en_c     = 1'b0;
            ifid_en_c   = 1'b0;
            idex_en_c   = 1'b0;
            exmem_clr_c = 1'b1;
            mc_busy_c   = 1'b1;
        end else if (hz.ex_branch_taken) begin
            ifid_clr_c = 1'b1;
            idex_clr_c = 1'b1;
        end else if (load_use) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_clr_c = 1'b1;
        end
    end

    assign hz.pc_en     = pc_en_c;
    assign hz.ifid_en   = ifid_en_c;
    assign hz.ifid_clr  = ifid_clr_c;
    assign hz.idex_en   = idex_en_c;
    assign hz.idex_clr  = idex_clr_c;
    assign hz.exmem_en  = exmem_en_c;
    assign hz.exmem_clr = exmem_clr_c;
    assign hz.memwb_en  = memwb_en_c;
    assign hz.mc_busy   = mc_busy_c;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_en_c && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
